// File: rtl/operand_fetch.sv
// ============================================================================
// operand_fetch
//
// Datapath-side command responder for the LWE accelerator. Accepts one
// command (opcode + operand base addresses), reads the DIMENSION+1 words of
// each ciphertext operand from a single-port scratchpad with one-cycle read
// latency, and streams them to the compute unit as ordered beats over a
// valid/ready handshake (mask elements first, body element last).
//
// Optional feature macro: OPERAND_FETCH_ADDR_CHECK_EN
//   defined   : commands whose operand span would pass the top of the address
//               space are rejected with a one-cycle err pulse.
//   undefined : no check; addresses wrap modulo 2^ADDR_WIDTH, err tied to 0.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_opcode          00 encrypt, 01 decrypt, 10 add, 11 mult
//   cmd_op1_addr        operand 1 base address
//   cmd_op2_addr        operand 2 base address (used when opcode[1]=1)
//   mem_rd_en/addr      scratchpad read request
//   mem_rd_data         read data, valid the cycle after mem_rd_en
//   out_valid/ready     operand beat handshake
//   out_op1/out_op2     operand elements (out_op2=0 for single-operand ops)
//   out_opcode          latched opcode
//   out_idx/out_last    element index, last marks the body element
//   busy                fetch in progress
//   done                one-cycle pulse after the last beat is accepted
//   err                 one-cycle pulse on a rejected command
// ============================================================================
module operand_fetch #(
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 10,
    parameter int ADDR_WIDTH       = 8,
    parameter int DIM_WIDTH        = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_opcode,
    input  logic [ADDR_WIDTH-1:0]       cmd_op1_addr,
    input  logic [ADDR_WIDTH-1:0]       cmd_op2_addr,
    output logic                        mem_rd_en,
    output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
    input  logic [CIPHERTEXT_WIDTH-1:0] mem_rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CIPHERTEXT_WIDTH-1:0] out_op1,
    output logic [CIPHERTEXT_WIDTH-1:0] out_op2,
    output logic [1:0]                  out_opcode,
    output logic [DIM_WIDTH-1:0]        out_idx,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_CAP  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic [DIM_WIDTH-1:0] LAST_IDX = DIM_WIDTH'(DIMENSION);

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [1:0]                  r_opcode;
    logic [ADDR_WIDTH-1:0]       r_op1_base;
    logic [ADDR_WIDTH-1:0]       r_op2_base;
    logic                        r_two_op;
    logic [DIM_WIDTH-1:0]        r_idx;
    logic [CIPHERTEXT_WIDTH-1:0] r_hold;
    logic [CIPHERTEXT_WIDTH-1:0] r_out_op1;
    logic [CIPHERTEXT_WIDTH-1:0] r_out_op2;
    logic [DIM_WIDTH-1:0]        r_out_idx;
    logic                        r_out_valid;
    logic                        r_done;

    logic                        w_accept;
    logic                        w_reject;
    logic                        w_range_bad;
    logic                        w_rd_en;
    logic [ADDR_WIDTH-1:0]       w_rd_addr;
    logic [ADDR_WIDTH-1:0]       w_idx_ext;

    assign w_idx_ext = ADDR_WIDTH'(r_idx);

`ifdef OPERAND_FETCH_ADDR_CHECK_EN
    // One extra bit catches a span that runs past the top address.
    localparam logic [ADDR_WIDTH:0] DIM_EXT = (ADDR_WIDTH+1)'(DIMENSION);
    logic [ADDR_WIDTH:0] w_op1_end;
    logic [ADDR_WIDTH:0] w_op2_end;
    logic                r_err;

    assign w_op1_end   = {1'b0, cmd_op1_addr} + DIM_EXT;
    assign w_op2_end   = {1'b0, cmd_op2_addr} + DIM_EXT;
    assign w_range_bad = w_op1_end[ADDR_WIDTH] | (cmd_opcode[1] & w_op2_end[ADDR_WIDTH]);
    assign err         = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_reject;
        end
    end
`else
    assign w_range_bad = 1'b0;
    assign err         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and read-port decode
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (w_range_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_RD_A;
                    end
                end
            end
            S_RD_A: begin
                w_rd_en     = 1'b1;
                w_rd_addr   = r_op1_base + w_idx_ext;
                w_state_nxt = r_two_op ? S_RD_B : S_CAP;
            end
            S_RD_B: begin
                w_rd_en     = 1'b1;
                w_rd_addr   = r_op2_base + w_idx_ext;
                w_state_nxt = S_CAP;
            end
            S_CAP: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = (r_idx == LAST_IDX) ? S_IDLE : S_RD_A;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch, element index, operand capture and beat register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opcode    <= '0;
            r_op1_base  <= '0;
            r_op2_base  <= '0;
            r_two_op    <= 1'b0;
            r_idx       <= '0;
            r_hold      <= '0;
            r_out_op1   <= '0;
            r_out_op2   <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_opcode   <= cmd_opcode;
                r_op1_base <= cmd_op1_addr;
                r_op2_base <= cmd_op2_addr;
                r_two_op   <= cmd_opcode[1];
                r_idx      <= '0;
            end
            // In RD_B the operand-1 word requested in RD_A is on the bus.
            if (r_state == S_RD_B) begin
                r_hold <= mem_rd_data;
            end
            if (r_state == S_CAP) begin
                if (r_two_op) begin
                    r_out_op1 <= r_hold;
                    r_out_op2 <= mem_rd_data;
                end else begin
                    r_out_op1 <= mem_rd_data;
                    r_out_op2 <= '0;
                end
                r_out_idx   <= r_idx;
                r_out_valid <= 1'b1;
            end
            if ((r_state == S_OUT) && out_ready) begin
                r_out_valid <= 1'b0;
                if (r_idx == LAST_IDX) begin
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // cmd_ready is gated by rst_n so it stays low for the whole reset window.
    assign cmd_ready   = rst_n && (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign mem_rd_en   = w_rd_en;
    assign mem_rd_addr = w_rd_addr;
    assign out_valid   = r_out_valid;
    assign out_op1     = r_out_op1;
    assign out_op2     = r_out_op2;
    assign out_opcode  = r_opcode;
    assign out_idx     = r_out_idx;
    assign out_last    = (r_out_idx == LAST_IDX);
    assign done        = r_done;

endmodule

// File: tb/tb_operand_fetch.sv
// ============================================================================
// tb_operand_fetch
//
// Self-checking bench for operand_fetch. A behavioural scratchpad answers the
// DUT's reads; each command's expected read addresses, beat contents and
// beat timing are derived from the command fields and the memory image.
// ============================================================================
module tb_operand_fetch;

    localparam int CW  = 10;
    localparam int DIM = 10;
    localparam int AW  = 8;
    localparam int DW  = 4;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_opcode;
    logic [AW-1:0] cmd_op1_addr;
    logic [AW-1:0] cmd_op2_addr;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [CW-1:0] mem_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_op1;
    logic [CW-1:0] out_op2;
    logic [1:0]    out_opcode;
    logic [DW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    logic [CW-1:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

    operand_fetch #(
        .CIPHERTEXT_WIDTH(CW),
        .DIMENSION       (DIM),
        .ADDR_WIDTH      (AW),
        .DIM_WIDTH       (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_op1_addr(cmd_op1_addr),
        .cmd_op2_addr(cmd_op2_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_opcode  (out_opcode),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratchpad: one-cycle read latency.
    initial mem_rd_data = '0;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_rd_en"},     32'(mem_rd_en), 32'd0);
        chk({tag, "_rd_addr"},   32'(mem_rd_addr), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_op1"},       32'(out_op1), 32'd0);
        chk({tag, "_op2"},       32'(out_op2), 32'd0);
        chk({tag, "_opcode"},    32'(out_opcode), 32'd0);
        chk({tag, "_idx"},       32'(out_idx), 32'd0);
        chk({tag, "_last"},      32'(out_last), 32'd0);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_done"},      32'(done), 32'd0);
        chk({tag, "_err"},       32'(err), 32'd0);
    endtask

    // Issues a command at the current negedge and follows it to completion.
    // stall_idx/stall_len: hold out_ready low on that beat for that many cycles.
    // inj_cyc: offer a second command while busy (-1 = none).
    // abort_idx: apply reset while that beat is presented (-1 = none).
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a1, input logic [7:0] a2,
                           input int stall_idx, input int stall_len,
                           input int inj_cyc, input int abort_idx);
        logic       two;
        logic [7:0] exp_addr[$];
        logic [7:0] ad;
        logic [CW-1:0] e1, e2;
        int  k, cyc, scnt, ai, seen, exp_lat, first, period, exp_t;
        bit  exp_done, fin;

        two    = op[1];
        first  = two ? 3 : 2;
        period = two ? 4 : 3;
        exp_addr = {};
        for (int i = 0; i <= DIM; i++) begin
            exp_addr.push_back(a1 + 8'(i));
            if (two) exp_addr.push_back(a2 + 8'(i));
        end
        exp_lat = period * (DIM + 1) + stall_len;

        cmd_opcode   = op;
        cmd_op1_addr = a1;
        cmd_op2_addr = a2;
        cmd_valid    = 1'b1;
        out_ready    = 1'b1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;

        k = 0; cyc = 0; scnt = 0; ai = 0; seen = -1;
        exp_done = 1'b0; fin = 1'b0;
        while (!fin) begin
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                chk("latency", 32'(cyc), 32'(exp_lat));
                chk("ready_in_done", 32'(cmd_ready), 32'd1);
                chk("busy_in_done", 32'(busy), 32'd0);
                chk("rd_en_in_done", 32'(mem_rd_en), 32'd0);
                chk("err_in_done", 32'(err), 32'd0);
                fin = 1'b1;
            end else begin
                chk("busy", 32'(busy), 32'd1);
                chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                if (cyc == 0) chk("first_rd_en", 32'(mem_rd_en), 32'd1);
                if (mem_rd_en) begin
                    if (ai < exp_addr.size()) chk("rd_addr", 32'(mem_rd_addr), 32'(exp_addr[ai]));
                    else chk("extra_read", 32'(ai), 32'(exp_addr.size()));
                    chk("rd_while_valid", 32'(out_valid), 32'd0);
                    ai++;
                end
                if (cyc == inj_cyc) begin
                    cmd_valid    = 1'b1;
                    cmd_opcode   = ~op;
                    cmd_op1_addr = 8'h99;
                    cmd_op2_addr = 8'h55;
                end else if (cyc == inj_cyc + 1) begin
                    cmd_valid = 1'b0;
                end
                if (out_valid) begin
                    ad = a1 + 8'(k);
                    e1 = mem[ad];
                    ad = a2 + 8'(k);
                    e2 = two ? mem[ad] : '0;
                    if (seen != k) begin
                        exp_t = first + period * k + ((stall_idx >= 0 && k > stall_idx) ? stall_len : 0);
                        chk("beat_time", 32'(cyc), 32'(exp_t));
                        seen = k;
                    end
                    chk("out_op1", 32'(out_op1), 32'(e1));
                    chk("out_op2", 32'(out_op2), 32'(e2));
                    chk("out_idx", 32'(out_idx), 32'(k));
                    chk("out_last", 32'(out_last), 32'(k == DIM));
                    chk("out_opcode", 32'(out_opcode), 32'(op));
                    if (k == abort_idx) begin
                        rst_n = 1'b0;
                        @(posedge clk);
                        @(negedge clk);
                        chk_all_zero("abort");
                        rst_n     = 1'b1;
                        out_ready = 1'b1;
                        @(negedge clk);
                        chk("abort_ready", 32'(cmd_ready), 32'd1);
                        chk("abort_no_done", 32'(done), 32'd0);
                        return;
                    end
                    if (k == stall_idx && scnt < stall_len) begin
                        out_ready = 1'b0;
                        scnt++;
                    end else begin
                        out_ready = 1'b1;
                        if (k == DIM) exp_done = 1'b1;
                        k++;
                    end
                end
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
                if (cyc > 600) begin
                    chk("timeout_cycles", 32'(cyc), 32'd600);
                    fin = 1'b1;
                end
            end
        end
        chk("read_count", 32'(ai), 32'(exp_addr.size()));
    endtask

    task automatic run_reject(input logic [1:0] op, input logic [7:0] a1, input logic [7:0] a2);
        cmd_opcode   = op;
        cmd_op1_addr = a1;
        cmd_op2_addr = a2;
        cmd_valid    = 1'b1;
        chk("rej_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_busy", 32'(busy), 32'd0);
        chk("rej_rd_en", 32'(mem_rd_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rej_err_clear", 32'(err), 32'd0);
            chk("rej_no_read", 32'(mem_rd_en), 32'd0);
            chk("rej_no_beat", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [1:0] rop;
        logic [7:0] ra1, ra2;
        int         sidx, slen;

        for (int i = 0; i < 256; i++) mem[i] = CW'($urandom);
        for (int i = 0; i <= DIM; i++) begin
            mem[i]        = CW'(i);
            mem[8'h20 + i] = CW'(10'h100 + i);
        end

        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_opcode   = 2'b00;
        cmd_op1_addr = '0;
        cmd_op2_addr = '0;
        out_ready    = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(cmd_ready), 32'd1);

        // Add: identity/offset memory image, no backpressure
        run_cmd(2'b10, 8'h00, 8'h20, -1, 0, -1, -1);
        // Decrypt back-to-back in the done cycle, with a command offered while busy
        run_cmd(2'b01, 8'h40, 8'h20, -1, 0, 5, -1);
        // Backpressure on beat 4 for 5 cycles
        run_cmd(2'b10, 8'h00, 8'h20, 4, 5, -1, -1);
        // Reset while beat 6 is presented, then a normal command
        run_cmd(2'b11, 8'h30, 8'h60, -1, 0, -1, 6);
        run_cmd(2'b00, 8'h10, 8'h00, -1, 0, -1, -1);

        // Top-of-address-space operand
`ifdef OPERAND_FETCH_ADDR_CHECK_EN
        run_reject(2'b00, 8'hF8, 8'h00);
        run_reject(2'b11, 8'h00, 8'hF9);
        run_cmd(2'b00, 8'hF5, 8'h00, -1, 0, -1, -1);
`else
        run_cmd(2'b00, 8'hF8, 8'h00, -1, 0, -1, -1);
        run_cmd(2'b11, 8'hFA, 8'hF7, -1, 0, -1, -1);
`endif

        // Randomized commands with random backpressure and idle gaps
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rop  = 2'($urandom_range(0, 3));
            ra1  = 8'($urandom_range(0, 245));
            ra2  = 8'($urandom_range(0, 245));
            sidx = $urandom_range(0, DIM);
            slen = $urandom_range(0, 3);
            run_cmd(rop, ra1, ra2, sidx, slen, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
